// File: rtl/fp_cvt_lanes_pkg.sv
// Shared types and constants for the BF16/FP32 lane converter.
package fp_cvt_pkg;

  // IEEE exception flags, packed MSB-first as {nv, of, uf, nx}.
  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  typedef enum logic {
    CVT_BF2F = 1'b0,
    CVT_F2BF = 1'b1
  } cvt_mode_e;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  localparam logic [31:0] QNAN_FP32 = 32'h7FC00000;
  localparam logic [15:0] QNAN_BF16 = 16'h7FC0;

endpackage

// File: rtl/fp_cvt_lanes_lane.sv
// Single-lane combinational BF16<->FP32 converter with IEEE flags.
module fp_cvt_lane
  import fp_cvt_pkg::*;
#(
  parameter bit FTZ = 1'b0
) (
  input  logic        mode,
  input  logic        rm,
  input  logic [31:0] x,
  output logic [31:0] y,
  output logic [3:0]  flags
);

  fp_flags_t   f;
  logic [7:0]  b_exp;
  logic [6:0]  b_man;
  logic [7:0]  f_exp;
  logic [22:0] f_man;
  logic [15:0] keep;
  logic        g;
  logic        st;
  logic        inc;
  logic [14:0] rnd;

  assign b_exp = x[14:7];
  assign b_man = x[6:0];
  assign f_exp = x[30:23];
  assign f_man = x[22:0];
  assign keep  = x[31:16];
  assign g     = x[15];
  assign st    = |x[14:0];
  // Round-to-nearest-even increments on guard when sticky or the kept LSB is set.
  assign inc   = (rm == RM_RNE) & g & (st | keep[0]);
  // Magnitude add; a mantissa carry ripples into the exponent field by itself.
  assign rnd   = keep[14:0] + {14'b0, inc};

  assign flags = f;

  // Select the converted value and flags for the requested direction.
  always_comb begin
    y = '0;
    f = '0;
    if (mode == CVT_BF2F) begin
      if (b_exp == 8'hFF && b_man != 7'd0) begin
        y    = QNAN_FP32;
        f.nv = ~b_man[6];
      end else if (FTZ && b_exp == 8'h00 && b_man != 7'd0) begin
        y    = {x[15], 31'b0};
        f.uf = 1'b1;
      end else begin
        y = {x[15:0], 16'h0000};
      end
    end else begin
      if (f_exp == 8'hFF && f_man != 23'd0) begin
        y    = {16'h0000, QNAN_BF16};
        f.nv = ~f_man[22];
      end else if (f_exp == 8'hFF) begin
        y = {16'h0000, keep};
      end else if (FTZ && f_exp == 8'h00 && f_man != 23'd0) begin
        y    = {16'h0000, x[31], 15'b0};
        f.uf = 1'b1;
      end else begin
        f.nx = g | st;
        if (rnd[14:7] == 8'hFF) begin
          // Finite input rounded past the largest normal.
          f.of = 1'b1;
          y    = {16'h0000, x[31], (rm == RM_RTZ) ? 15'h7F7F : 15'h7F80};
        end else begin
          f.uf = (rnd[14:7] == 8'h00) && (x[30:0] != 31'd0) && (g | st);
          y    = {16'h0000, x[31], rnd};
        end
      end
    end
  end

endmodule

// File: rtl/fp_cvt_lanes.sv
// Multi-lane pipelined BF16/FP32 converter: S1 holds converted results,
// S2 is the output register, fpcsr accumulates sticky flags.
//
// Handshake: a beat transfers on a port when valid & ready are both high at
// the rising clock edge. valid never depends on ready; once out_valid is high
// out_data/out_flags hold until out_ready accepts them. in_ready is a
// combinational chain from out_ready so a full pipe still moves 1 beat/cycle.
module fp_cvt_lanes
  import fp_cvt_pkg::*;
#(
  parameter int LANES = 4,
  parameter bit FTZ   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic                 in_rm,
  input  logic [LANES-1:0]     in_lane_en,
  input  logic [32*LANES-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*LANES-1:0]  out_data,
  output logic [3:0]           out_flags,
  output logic [3:0]           fpcsr,
  input  logic                 fpcsr_clr
);

  logic [LANES-1:0][31:0] lane_y;
  logic [LANES-1:0][3:0]  lane_f;
  logic [32*LANES-1:0]    cvt_data;
  logic [3:0]             beat_flags;

  logic                   s1_v;
  logic [32*LANES-1:0]    s1_data;
  logic [3:0]             s1_flags;
  logic                   s2_load;
  logic                   s1_load;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_cvt_lane #(.FTZ(FTZ)) u_lane (
      .mode  (in_mode),
      .rm    (in_rm),
      .x     (in_data[32*i +: 32]),
      .y     (lane_y[i]),
      .flags (lane_f[i])
    );
  end

  // Mask disabled lanes to zero and OR the enabled lanes' flags.
  always_comb begin
    cvt_data   = '0;
    beat_flags = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane_en[i]) begin
        cvt_data[32*i +: 32] = lane_y[i];
        beat_flags           = beat_flags | lane_f[i];
      end
    end
  end

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_v || s2_load;
  assign in_ready = s1_load;

  // S1: capture the converted beat whenever the stage can advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v     <= 1'b0;
      s1_data  <= '0;
      s1_flags <= '0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_data  <= cvt_data;
        s1_flags <= beat_flags;
      end
    end
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (s2_load) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_data  <= s1_data;
        out_flags <= s1_flags;
      end
    end
  end

  // Sticky flags: a beat's flags survive a clear issued in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpcsr <= '0;
    end else if (s2_load && s1_v) begin
      fpcsr <= (fpcsr_clr ? 4'b0000 : fpcsr) | s1_flags;
    end else if (fpcsr_clr) begin
      fpcsr <= '0;
    end
  end

endmodule

// File: tb/tb_fp_cvt_lanes.sv
// Directed bench for fp_cvt_lanes with hand-computed expected values.
module tb_fp_cvt_lanes;

  localparam int LANES = 4;
  localparam int W     = 32 * LANES;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic             in_rm;
  logic [LANES-1:0] in_lane_en;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [3:0]       out_flags;
  logic [3:0]       fpcsr;
  logic             fpcsr_clr;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           mon_en = 1'b0;

  fp_cvt_lanes #(.LANES(LANES), .FTZ(1'b0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_rm      (in_rm),
    .in_lane_en (in_lane_en),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_flags  (out_flags),
    .fpcsr      (fpcsr),
    .fpcsr_clr  (fpcsr_clr)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Collect every output transfer; inputs change only just after posedge.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mode, input logic rm, input logic [3:0] en,
                       input logic [W-1:0] data);
    in_valid   = 1'b1;
    in_mode    = mode;
    in_rm      = rm;
    in_lane_en = en;
    in_data    = data;
    tick();
    in_valid   = 1'b0;
  endtask

  // One beat through an unstalled pipe, checked at its 2-cycle output slot.
  task automatic beat(input string tag, input logic mode, input logic rm,
                      input logic [3:0] en, input logic [W-1:0] data,
                      input logic [W-1:0] exp_d, input logic [3:0] exp_f);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1'b1));
    drive(mode, rm, en, data);
    chk({tag, "_early_valid"}, W'(out_valid), W'(1'b0));
    tick();
    chk({tag, "_valid"}, W'(out_valid), W'(1'b1));
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_flags"}, W'(out_flags), W'(exp_f));
  endtask

  function automatic logic [W-1:0] bp_in(input int i);
    logic [W-1:0] d;
    d = '0;
    for (int j = 0; j < LANES; j++) d[32*j +: 16] = 16'h4000 + 16'(i * 16 + j);
    return d;
  endfunction

  function automatic logic [W-1:0] bp_exp(input int i);
    logic [W-1:0] d;
    d = '0;
    for (int j = 0; j < LANES; j++) d[32*j +: 32] = {16'h4000 + 16'(i * 16 + j), 16'h0000};
    return d;
  endfunction

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_mode    = 1'b0;
    in_rm      = 1'b0;
    in_lane_en = '0;
    in_data    = '0;
    out_ready  = 1'b1;
    fpcsr_clr  = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_flags", W'(out_flags), W'(4'b0000));
    chk("rst_fpcsr", W'(fpcsr), W'(4'b0000));
    #3 reset_n = 1'b1;
    tick();
    chk("rst_in_ready", W'(in_ready), W'(1'b1));

    // BF16->FP32: 1.0, sNaN, preserved subnormal, disabled lane holding a NaN.
    beat("bf2f", 1'b0, 1'b0, 4'b0111,
         {32'h00007F81, 32'h00000001, 32'h0000FF81, 32'h00003F80},
         {32'h00000000, 32'h00010000, 32'h7FC00000, 32'h3F800000}, 4'b1000);
    chk("bf2f_fpcsr", W'(fpcsr), W'(4'b1000));

    // FP32->BF16 rounding: tie-to-even down, tie-to-even up, above half.
    beat("rne", 1'b1, 1'b0, 4'b0111,
         {32'h00000000, 32'h3F808001, 32'h3F818000, 32'h3F808000},
         {32'h00000000, 32'h00003F81, 32'h00003F82, 32'h00003F80}, 4'b0001);
    beat("rtz", 1'b1, 1'b1, 4'b0111,
         {32'h00000000, 32'h3F808001, 32'h3F818000, 32'h3F808000},
         {32'h00000000, 32'h00003F80, 32'h00003F81, 32'h00003F80}, 4'b0001);
    chk("rnd_fpcsr", W'(fpcsr), W'(4'b1001));

    // Overflow, underflow and an exact subnormal in one beat.
    beat("of_uf", 1'b1, 1'b0, 4'b0111,
         {32'h00000000, 32'h00400000, 32'h00000001, 32'h7F7FFFFF},
         {32'h00000000, 32'h00000040, 32'h00000000, 32'h00007F80}, 4'b0111);
    beat("of_rtz", 1'b1, 1'b1, 4'b0001,
         {32'h00000000, 32'h00000000, 32'h00000000, 32'h7F7FFFFF},
         {32'h00000000, 32'h00000000, 32'h00000000, 32'h00007F7F}, 4'b0001);
    beat("uf_only", 1'b1, 1'b0, 4'b0001,
         {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001},
         '0, 4'b0011);
    beat("exact_sub", 1'b1, 1'b0, 4'b0001,
         {32'h00000000, 32'h00000000, 32'h00000000, 32'h00400000},
         {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000040}, 4'b0000);
    // Specials: sNaN, -inf, -0, qNaN.
    beat("special", 1'b1, 1'b0, 4'b1111,
         {32'h7FC00001, 32'h80000000, 32'hFF800000, 32'h7F800001},
         {32'h00007FC0, 32'h00008000, 32'h0000FF80, 32'h00007FC0}, 4'b1000);
    chk("acc_fpcsr", W'(fpcsr), W'(4'b1111));

    // Clear coinciding with an NX beat keeps NX; clear alone zeroes.
    drive(1'b1, 1'b0, 4'b0001, {96'h0, 32'h3F808000});
    fpcsr_clr = 1'b1;
    tick();
    chk("clr_with_beat_fpcsr", W'(fpcsr), W'(4'b0001));
    chk("clr_with_beat_flags", W'(out_flags), W'(4'b0001));
    tick();
    chk("clr_alone_fpcsr", W'(fpcsr), W'(4'b0000));
    fpcsr_clr = 1'b0;

    // Backpressure: two beats fill the pipe, the third waits.
    exp_q.delete();
    got_q.delete();
    mon_en    = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_rm     = 1'b0;
    in_lane_en = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      in_data = bp_in(i);
      chk($sformatf("bp_ready_%0d", i), W'(in_ready), W'(1'b1));
      exp_q.push_back(bp_exp(i));
      tick();
    end
    in_data = bp_in(2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_stall_ready_%0d", k), W'(in_ready), W'(1'b0));
      chk($sformatf("bp_stall_valid_%0d", k), W'(out_valid), W'(1'b1));
      chk($sformatf("bp_stall_data_%0d", k), out_data, bp_exp(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", W'(in_ready), W'(1'b1));
    for (int i = 2; i < 5; i++) begin
      in_data = bp_in(i);
      exp_q.push_back(bp_exp(i));
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    mon_en = 1'b0;
    chk("bp_count", W'(got_q.size()), W'(exp_q.size()));
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) chk($sformatf("bp_beat_%0d", i), got_q[i], exp_q[i]);
    end

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_rm     = 1'b0;
    in_lane_en = 4'b0001;
    in_data   = {96'h0, 32'h3F808000};
    tick();
    tick();
    in_valid = 1'b0;
    chk("inflight_valid", W'(out_valid), W'(1'b1));
    chk("inflight_fpcsr", W'(fpcsr), W'(4'b0001));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), W'(1'b0));
    chk("arst_fpcsr", W'(fpcsr), W'(4'b0000));
    chk("arst_out_data", out_data, '0);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_valid", W'(out_valid), W'(1'b0));
    beat("post_rst", 1'b0, 1'b0, 4'b0001,
         {96'h0, 32'h00003F80}, {96'h0, 32'h3F800000}, 4'b0000);
    chk("post_rst_fpcsr", W'(fpcsr), W'(4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_cvt_lanes.md
Name: fp_cvt_lanes

Overview:
Multi-lane, pipelined bidirectional BF16/FP32 format converter with valid/ready handshake. Per-beat mode selects BF16->FP32 (exact widening) or FP32->BF16 (narrowing with RNE or RTZ rounding). Produces per-beat IEEE exception flags and a sticky 4-bit fpcsr. Sits between the accelerator operand buffer and the BF16 datapath, and supersedes the single-lane, widen-only converter.

Parameters:
LANES, 4, number of independent conversion lanes (1..16)
FTZ, 0, 1 = flush subnormal inputs and outputs to signed zero (sets UF on a flushed nonzero output)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  converter can accept a beat
in_mode  in  1  0 = BF16->FP32, 1 = FP32->BF16
in_rm  in  1  0 = round-nearest-even, 1 = round-toward-zero (FP32->BF16 only)
in_lane_en  in  LANES  per-lane enable
in_data  in  32*LANES  lane i at [32i+31:32i]; BF16 operands occupy bits [15:0] of each lane
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  32*LANES  FP32 results, or BF16 results in [15:0] with [31:16] = 0
out_flags  out  4  OR across enabled lanes of {NV,OF,UF,NX} for this beat
fpcsr  out  4  sticky {NV,OF,UF,NX}
fpcsr_clr  in  1  synchronous clear of fpcsr

Behaviour:
- Reset (async, reset_n = 0): s1/s2 valid = 0; out_data = 0; out_flags = 0; fpcsr = 0; in_ready = 1 once reset_n is released. Any in-flight beats are discarded.
- Pipeline: S1 registers decode, convert and round results. S2 is the output register. Latency is 2 cycles from the in_valid & in_ready edge to out_valid when there is no stall.
- Stage advance: S2 loads when !s2_v || out_ready. S1 loads when !s1_v || S2 loads. in_ready = !s1_v || S2-load. This is a combinational ready chain with no bubbles at full throughput (1 beat/cycle).
- out_data and out_flags are stable while out_valid & !out_ready. No beat is lost or duplicated.
- Disabled lane: output 0, contributes no flags.
- BF16->FP32: {s,e,m} -> {s,e,m,16'h0}. Exact, NX = 0.
  - NaN -> 32'h7FC00000, with NV set iff signalling (m[6] = 0).
  - Subnormals are preserved unless FTZ.
- FP32->BF16: keep = x[31:16], g = x[15], st = |x[14:0].
  - Rounding increment: RNE: inc = g & (st | keep[0]). RTZ: inc = 0.
  - The 16-bit add carries into the exponent naturally.
  - NX = g | st.
  - OF: finite input whose rounded exponent becomes 8'hFF. Result is ±inf (RNE) or ±7F7F (RTZ). OF implies NX.
  - UF: rounded result is subnormal or zero from a nonzero input, and NX.
  - Inf passes through unflagged.
  - NaN -> 16'h7FC0; NV iff signalling (x[22] = 0). NaN never sets NX.
- fpcsr update: each cycle S2 loads a valid beat, fpcsr <= (fpcsr_clr ? 0 : fpcsr) | new_flags. When fpcsr_clr and a new flag occur in the same cycle, the new flag survives.
- Mode and rm are captured per beat. Alternating modes on consecutive beats are legal.

Decomposition:
- Package fp_cvt_pkg:
  - typedef fp_flags_t {nv,of,uf,nx}
  - enum cvt_mode_e {CVT_BF2F, CVT_F2BF}
  - enum rm_e {RM_RNE, RM_RTZ}
  - constants QNAN_FP32 = 32'h7FC00000, QNAN_BF16 = 16'h7FC0
- Sub-module fp_cvt_lane: purely combinational single-lane converter (mode, rm, FTZ in; result, flags out), instantiated LANES times by generate. The top holds the pipeline, handshake and fpcsr.

Test Plan:
- LANES = 4, mode 0, lane0 = 16'h3F80, lane1 = 16'hFF81 (sNaN) -> after 2 cycles lane0 = 32'h3F800000, lane1 = 32'h7FC00000, out_flags = NV, fpcsr = 4'b1000.
- Mode 1, RNE: 32'h3F808000 -> 16'h3F80; 32'h3F818000 -> 16'h3F82; 32'h3F808001 -> 16'h3F81; out_flags = NX. Same inputs with RTZ -> 3F80, 3F81, 3F80.
- Mode 1: 32'h7F7FFFFF RNE -> 16'h7F80 with OF|NX; RTZ -> 16'h7F7F with NX only. 32'h00000001 -> 16'h0000 with UF|NX. 32'h00400000 -> 16'h0040 with no flags.
- Backpressure: 5 back-to-back beats, out_ready held low for cycles 2-6 -> in_ready drops after 2 beats are held; all 5 beats emerge in order with stable data while stalled.
- fpcsr_clr asserted in the same cycle as a beat raising NX -> fpcsr = 4'b0001. fpcsr_clr alone -> 0.
- reset_n pulsed low while 2 beats are in flight -> out_valid = 0, fpcsr = 0 immediately; in_ready = 1 after release; the next beat converts correctly.
